result_bus_arbiter: RTL and testbench

//  Collects finished results from NUM_UNITS execution-unit wrappers (each exposing output_valid/ready,
//  rs_id_out, result_reg_addr_out, result, cr0_xer) and serialises them onto one common result bus.
//  The bus drives every reservation station's update_op_valid/rs_id/value inputs and the GPR/CR writeback.

---
 rtl/result_bus_arbiter_pkg.sv | 15 +
 rtl/result_bus_arbiter_if.sv | 34 +++
 rtl/result_bus_arbiter_rr_arbiter.sv | 54 +++++
 rtl/result_bus_arbiter.sv | 73 +++++++
 tb/tb_result_bus_arbiter.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/result_bus_arbiter_pkg.sv
// Shared types for the common result bus: CR0/XER status carried with every result.
// Imported by the arbiter, its interface and the bench.
package result_bus_arbiter_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam int VALUE_WIDTH    = 32;

  typedef struct packed {
    logic [0:3] cr0;
    logic       so;
    logic       ov;
    logic       ca;
  } cond_exception_t;

endpackage

// File: rtl/result_bus_arbiter_if.sv
// Execution-unit result ports plus the broadcast result bus, with views for the arbiter (slave)
// and for the units/writeback side (master).
interface result_bus_arbiter_if
  import result_bus_arbiter_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int RS_ID_WIDTH = 5
) ();

  logic [NUM_UNITS-1:0]                      in_valid;
  logic [NUM_UNITS-1:0]                      in_ready;
  logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0]     in_rs_id;
  logic [NUM_UNITS-1:0][REG_ADDR_WIDTH-1:0]  in_reg_addr;
  logic [NUM_UNITS-1:0][0:VALUE_WIDTH-1]     in_result;
  cond_exception_t [NUM_UNITS-1:0]           in_cr0_xer;

  logic                      cdb_valid;
  logic                      cdb_ready;
  logic [RS_ID_WIDTH-1:0]    cdb_rs_id;
  logic [0:VALUE_WIDTH-1]    cdb_value;
  logic [REG_ADDR_WIDTH-1:0] cdb_reg_addr;
  cond_exception_t           cdb_cr0_xer;

  modport master (
    output in_valid, in_rs_id, in_reg_addr, in_result, in_cr0_xer, cdb_ready,
    input  in_ready, cdb_valid, cdb_rs_id, cdb_value, cdb_reg_addr, cdb_cr0_xer
  );

  modport slave (
    input  in_valid, in_rs_id, in_reg_addr, in_result, in_cr0_xer, cdb_ready,
    output in_ready, cdb_valid, cdb_rs_id, cdb_value, cdb_reg_addr, cdb_cr0_xer
  );

endinterface

// File: rtl/result_bus_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer, combinational.
// Pointer moves to one past the granted unit only when the caller reports an accepted grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   scan;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan      = '0;
    for (int k = 0; k < N; k++) begin
      scan = {1'b0, ptr} + (PW+1)'(k);
      if (scan >= (PW+1)'(N)) begin
        scan = scan - (PW+1)'(N);
      end
      if (!found && req[scan[PW-1:0]]) begin
        grant[scan[PW-1:0]] = 1'b1;
        grant_idx           = scan[PW-1:0];
        found               = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (advance) begin
      ptr_next = (grant_idx == PW'(N-1)) ? '0 : grant_idx + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/result_bus_arbiter.sv
// Serialises unit results onto one registered result bus; accept-to-bus latency 1 cycle.
// Single output buffer reloads while draining, so full throughput when writeback is ready.
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int NUM_UNITS   = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input logic                clk,
  input logic                rst,
  result_bus_arbiter_if.slave bus
);

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0]    rs_id;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [0:VALUE_WIDTH-1]    value;
    cond_exception_t           cr0_xer;
  } cdb_entry_t;

  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] ready;
  logic                 can_load;
  logic                 transfer;
  cdb_entry_t           sel;
  cdb_entry_t           cdb_q;
  logic                 cdb_valid_q;

  rr_arbiter #(.N(NUM_UNITS)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.in_valid),
    .advance (transfer),
    .grant   (grant)
  );

  assign can_load     = !cdb_valid_q || bus.cdb_ready;
  assign ready        = (can_load && !rst) ? grant : '0;
  assign transfer     = |(ready & bus.in_valid);
  assign bus.in_ready = ready;

  // Grant is one-hot, so a plain priority select is an exact mux.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (grant[i]) begin
        sel.rs_id    = bus.in_rs_id[i];
        sel.reg_addr = bus.in_reg_addr[i];
        sel.value    = bus.in_result[i];
        sel.cr0_xer  = bus.in_cr0_xer[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_q       <= '0;
    end else if (transfer) begin
      cdb_valid_q <= 1'b1;
      cdb_q       <= sel;
    end else if (bus.cdb_ready) begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign bus.cdb_valid    = cdb_valid_q;
  assign bus.cdb_rs_id    = cdb_q.rs_id;
  assign bus.cdb_reg_addr = cdb_q.reg_addr;
  assign bus.cdb_value    = cdb_q.value;
  assign bus.cdb_cr0_xer  = cdb_q.cr0_xer;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Bench for result_bus_arbiter: cycle model of grant/buffer plus a result scoreboard.
module tb_result_bus_arbiter;
  import result_bus_arbiter_pkg::*;

  localparam int NU = 4;
  localparam int RW = 5;

  typedef struct packed {
    logic [RW-1:0] rs_id;
    logic [4:0]    reg_addr;
    logic [31:0]   value;
    logic [6:0]    cr;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  exp_t          sb[$];
  logic          m_valid;
  int            m_ptr;
  logic [NU-1:0] obs_ready;
  logic          obs_valid;
  logic [31:0]   obs_value;
  int            last_grant;

  result_bus_arbiter_if #(.NUM_UNITS(NU), .RS_ID_WIDTH(RW)) bus ();

  result_bus_arbiter #(.NUM_UNITS(NU), .RS_ID_WIDTH(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NU-1:0] v, input int p);
    for (int k = 0; k < NU; k++) begin
      int idx;
      idx = (p + k) % NU;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_unit(input int i, input logic v, input logic [RW-1:0] rs,
                          input logic [4:0] ra, input logic [31:0] val);
    bus.in_valid[i]    = v;
    bus.in_rs_id[i]    = rs;
    bus.in_reg_addr[i] = ra;
    bus.in_result[i]   = val;
    bus.in_cr0_xer[i]  = cond_exception_t'(7'(i * 9 + 3));
  endtask

  task automatic set_all_valid(input logic v);
    for (int i = 0; i < NU; i++) bus.in_valid[i] = v;
  endtask

  // One clock: sample mid-cycle, compare against the model, advance the model, cross the edge.
  task automatic step();
    int            g;
    int            bump;
    exp_t          e;
    logic [NU-1:0] exp_rdy;
    logic          can_load;
    #3;
    can_load = !m_valid || bus.cdb_ready;
    g = (rst || !can_load) ? -1 : pick(bus.in_valid, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_ready  = bus.in_ready;
    obs_valid  = bus.cdb_valid;
    obs_value  = bus.cdb_value;
    last_grant = -1;
    for (int k = 0; k < NU; k++) if (obs_ready[k]) last_grant = k;
    check_eq("in_ready", bus.in_ready, exp_rdy);
    check_eq("cdb_valid", bus.cdb_valid, m_valid);
    if (m_valid && bus.cdb_ready) begin
      check_eq("sb_size", sb.size(), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_eq("cdb_rs_id", bus.cdb_rs_id, e.rs_id);
        check_eq("cdb_value", bus.cdb_value, e.value);
        check_eq("cdb_reg_addr", bus.cdb_reg_addr, e.reg_addr);
        check_eq("cdb_cr0_xer", bus.cdb_cr0_xer, e.cr);
      end
    end
    bump = -1;
    if (rst) begin
      m_valid = 1'b0;
      m_ptr   = 0;
      sb.delete();
    end else if (g >= 0) begin
      e.rs_id    = bus.in_rs_id[g];
      e.reg_addr = bus.in_reg_addr[g];
      e.value    = bus.in_result[g];
      e.cr       = bus.in_cr0_xer[g];
      sb.push_back(e);
      m_valid = 1'b1;
      m_ptr   = (g + 1) % NU;
      bump    = g;
    end else if (bus.cdb_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (bump >= 0) begin
      bus.in_result[bump] = bus.in_result[bump] + 32'd1;
      bus.in_rs_id[bump]  = bus.in_rs_id[bump] + RW'(1);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cdb_ready = 1'b1;
    for (int i = 0; i < NU; i++) set_unit(i, 1'b0, RW'(i), 5'(i + 8), 32'h1000_0000 * i);
    m_valid = 1'b0;
    m_ptr   = 0;
    @(posedge clk);
    #1;

    // Reset held with every unit requesting.
    set_all_valid(1'b1);
    step();
    step();
    check_eq("rst_cdb_valid", obs_valid, 1'b0);
    rst = 1'b0;
    set_all_valid(1'b0);

    // Single unit.
    set_unit(2, 1'b1, 5'd5, 5'd7, 32'hDEADBEEF);
    step();
    check_eq("single_grant", obs_ready, 4'b0100);
    bus.in_valid[2] = 1'b0;
    step();
    check_eq("single_valid", obs_valid, 1'b1);
    check_eq("single_value", obs_value, 32'hDEADBEEF);
    step();
    check_eq("single_drain", obs_valid, 1'b0);

    // Round-robin from a fresh pointer, no bubbles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_all_valid(1'b1);
    for (int n = 0; n < 8; n++) begin
      step();
      check_eq("rr_order", last_grant, n % NU);
      if (n > 0) check_eq("rr_nobubble", obs_valid, 1'b1);
    end

    // Backpressure with unit3 waiting.
    set_all_valid(1'b0);
    set_unit(1, 1'b1, 5'd3, 5'd9, 32'h12345678);
    step();
    check_eq("bp_grant1", last_grant, 1);
    bus.in_valid[1] = 1'b0;
    set_unit(3, 1'b1, 5'd11, 5'd12, 32'hCAFEF00D);
    bus.cdb_ready = 1'b0;
    repeat (5) begin
      step();
      check_eq("bp_hold", obs_value, 32'h12345678);
      check_eq("bp_stall", obs_ready, 4'b0000);
    end
    bus.cdb_ready = 1'b1;
    step();
    check_eq("bp_release", obs_ready, 4'b1000);
    bus.in_valid[3] = 1'b0;
    step();
    check_eq("bp_unit3", obs_value, 32'hCAFEF00D);

    // Wrap: pointer parked at 3, units 0 and 3 alternate.
    set_unit(2, 1'b1, 5'd20, 5'd21, 32'h2222_0000);
    step();
    check_eq("wrap_setup", last_grant, 2);
    bus.in_valid[2] = 1'b0;
    bus.in_valid[0] = 1'b1;
    bus.in_valid[3] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      check_eq("wrap_order", last_grant, (n % 2 == 0) ? 3 : 0);
    end

    // Reset while the bus holds a result.
    bus.cdb_ready = 1'b0;
    rst = 1'b1;
    step();
    check_eq("mid_rst_rdy", obs_ready, 4'b0000);
    rst = 1'b0;
    bus.cdb_ready = 1'b1;
    set_all_valid(1'b1);
    step();
    check_eq("mid_rst_valid", obs_valid, 1'b0);
    check_eq("mid_rst_first", last_grant, 0);
    set_all_valid(1'b0);
    step();
    step();
    check_eq("final_idle", obs_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
